// File: rtl/openserdes_deserializer_pkg.sv
// Shared constants, FSM state type and counter-width helper for the openserdes deserializer.
package openserdes_pkg;

    localparam int NUM_WORDS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } deser_state_e;

    function automatic int cntWidth(input int wordW);
        return $clog2(wordW) + 1;
    endfunction

endpackage

// File: rtl/openserdes_deserializer_if.sv
// Serial-in / parallel-out bundle of openserdes_deserializer.
// DESER_WORD_STROBE_EN adds the per-word WORD_OUT/WORD_VALID strobe signals.
interface openserdes_deserializer_if
    import openserdes_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = cntWidth(WORD_W)
);
    logic              SERIAL_IN;
    logic              BIT_VALID;
    logic              SOF;
    logic [WORD_W-1:0] PAR_OUT1;
    logic [WORD_W-1:0] PAR_OUT2;
    logic [WORD_W-1:0] PAR_OUT3;
    logic [WORD_W-1:0] PAR_OUT4;
    logic [WORD_W-1:0] PAR_OUT5;
    logic [WORD_W-1:0] PAR_OUT6;
    logic [WORD_W-1:0] PAR_OUT7;
    logic [WORD_W-1:0] PAR_OUT8;
    logic              FRAME_VALID;
    logic              FRAME_ERR;
    logic [CNT_W-1:0]  COUNT;
    logic [3:0]        SAMPLE_COUNT;
`ifdef DESER_WORD_STROBE_EN
    logic [WORD_W-1:0] WORD_OUT;
    logic              WORD_VALID;

    modport master (
        output SERIAL_IN, BIT_VALID, SOF,
        input  PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4,
        input  PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8,
        input  FRAME_VALID, FRAME_ERR, COUNT, SAMPLE_COUNT,
        input  WORD_OUT, WORD_VALID
    );

    modport slave (
        input  SERIAL_IN, BIT_VALID, SOF,
        output PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4,
        output PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8,
        output FRAME_VALID, FRAME_ERR, COUNT, SAMPLE_COUNT,
        output WORD_OUT, WORD_VALID
    );
`else
    modport master (
        output SERIAL_IN, BIT_VALID, SOF,
        input  PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4,
        input  PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8,
        input  FRAME_VALID, FRAME_ERR, COUNT, SAMPLE_COUNT
    );

    modport slave (
        input  SERIAL_IN, BIT_VALID, SOF,
        output PAR_OUT1, PAR_OUT2, PAR_OUT3, PAR_OUT4,
        output PAR_OUT5, PAR_OUT6, PAR_OUT7, PAR_OUT8,
        output FRAME_VALID, FRAME_ERR, COUNT, SAMPLE_COUNT
    );
`endif

endinterface

// File: rtl/openserdes_deserializer_shift_rx.sv
// LSB-first receive shift register with bit counter; word/word_done describe the
// word completed by the bit being accepted this cycle.
module openserdes_shift_rx
    import openserdes_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = cntWidth(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    input  logic              clr,
    output logic [WORD_W-1:0] word,
    output logic              word_done,
    output logic [CNT_W-1:0]  count
);

    logic [WORD_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] w_base;
    logic [CNT_W-1:0]  w_countBase;
    logic              w_lastBit;

    // clr makes the accepted bit the first bit of a fresh word
    assign w_base      = clr ? '0 : r_shreg;
    assign w_countBase = clr ? '0 : r_count;
    assign w_lastBit   = (w_countBase == CNT_W'(WORD_W - 1));
    assign word        = {din, w_base[WORD_W-1:1]};
    assign word_done   = en && w_lastBit;
    assign count       = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (en) begin
            r_shreg <= word;
            r_count <= w_lastBit ? '0 : w_countBase + 1'b1;
        end
    end

endmodule

// File: rtl/openserdes_deserializer.sv
// Receive end of the openserdes link: FSM, 8-word bank and frame output registers.
// Define DESER_WORD_STROBE_EN to add the per-word WORD_OUT/WORD_VALID strobe.
module openserdes_deserializer
    import openserdes_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    openserdes_deserializer_if.slave bus
);

    localparam int CNT_W = cntWidth(WORD_W);

    deser_state_e      r_state;
    logic [WORD_W-1:0] r_bank   [NUM_WORDS];
    logic [WORD_W-1:0] r_parOut [NUM_WORDS];
    logic [3:0]        r_sampleCount;
    logic              r_frameValid;
    logic              r_frameErr;

    logic              w_en;
    logic              w_clr;
    logic              w_abort;
    logic              w_wordDone;
    logic [WORD_W-1:0] w_word;
    logic [CNT_W-1:0]  w_count;

    assign w_clr   = bus.BIT_VALID && bus.SOF;
    assign w_en    = bus.BIT_VALID && ((r_state == RECV) || bus.SOF);
    // In RECV only word1/bit0 is a legal SOF position; any other SOF aborts the frame
    assign w_abort = w_clr && (r_state == RECV) && ((w_count != '0) || (r_sampleCount != '0));

    openserdes_shift_rx #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_shiftRx (
        .clk       (CLK),
        .rst_n     (RESET),
        .en        (w_en),
        .din       (bus.SERIAL_IN),
        .clr       (w_clr),
        .word      (w_word),
        .word_done (w_wordDone),
        .count     (w_count)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= IDLE;
            r_sampleCount <= '0;
            r_frameValid  <= 1'b0;
            r_frameErr    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_bank[i]   <= '0;
                r_parOut[i] <= '0;
            end
        end else begin
            r_frameValid <= 1'b0;
            r_frameErr   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clr) begin
                        r_state       <= RECV;
                        r_sampleCount <= '0;
                    end
                end
                RECV: begin
                    if (w_abort) begin
                        r_frameErr    <= 1'b1;
                        r_sampleCount <= '0;
                    end else if (w_wordDone) begin
                        r_bank[r_sampleCount[2:0]] <= w_word;
                        // Last word bypasses the bank so all eight outputs update together
                        if (r_sampleCount == 4'(NUM_WORDS - 1)) begin
                            for (int i = 0; i < NUM_WORDS; i++) begin
                                r_parOut[i] <= (i == NUM_WORDS - 1) ? w_word : r_bank[i];
                            end
                            r_frameValid  <= 1'b1;
                            r_sampleCount <= '0;
                            r_state       <= IDLE;
                        end else begin
                            r_sampleCount <= r_sampleCount + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.PAR_OUT1     = r_parOut[0];
    assign bus.PAR_OUT2     = r_parOut[1];
    assign bus.PAR_OUT3     = r_parOut[2];
    assign bus.PAR_OUT4     = r_parOut[3];
    assign bus.PAR_OUT5     = r_parOut[4];
    assign bus.PAR_OUT6     = r_parOut[5];
    assign bus.PAR_OUT7     = r_parOut[6];
    assign bus.PAR_OUT8     = r_parOut[7];
    assign bus.FRAME_VALID  = r_frameValid;
    assign bus.FRAME_ERR    = r_frameErr;
    assign bus.COUNT        = w_count;
    assign bus.SAMPLE_COUNT = r_sampleCount;

`ifdef DESER_WORD_STROBE_EN
    logic [WORD_W-1:0] r_wordOut;
    logic              r_wordValid;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wordOut   <= '0;
            r_wordValid <= 1'b0;
        end else begin
            r_wordValid <= w_wordDone;
            if (w_wordDone) begin
                r_wordOut <= w_word;
            end
        end
    end

    assign bus.WORD_OUT   = r_wordOut;
    assign bus.WORD_VALID = r_wordValid;
`endif

endmodule
